fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Output reorder buffer at the tail of the 32-point SDF FFT pipeline. The last
//  butterfly stage emits each frame in bit-reversed index order; this block
//  accepts one complex sample per cycle and re-emits every frame in natural order.
//  Ping-pong storage (2 banks x N entries) sustains 1 sample/cycle with valid/ready.
// PARAMETERS
//  N      32  points per frame (power of 2)
//  LOG2N  5   log2(N); index/counter width
//  DW     15  bits per real/imag component (two's complement, passed bit-exact)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   reset: asynchronous, active-high
//  in_valid   in   1   input sample present
//  in_ready   out  1   block can accept input this cycle
//  in_r       in   DW  real part, bit-reversed arrival order
//  in_i       in   DW  imag part
//  out_valid  out  1   output sample present (registered)
//  out_ready  in   1   downstream accepts output this cycle
//  out_r      out  DW  real part, natural order (registered)
//  out_i      out  DW  imag part (registered)
//  out_first  out  1   high with index-0 sample of a frame
//  out_last   out  1   high with index-(N-1) sample of a frame
// BEHAVIOUR
//  - Reset: wbank=rbank=0, wcnt=rcnt=0, full[1:0]=0; out_valid/out_first/
//    out_last=0, out_r/out_i=0. in_ready=1 in the first cycle after reset release.
//    rst mid-frame discards all partial and buffered frames; no output follows.
//  - in_ready = !full[wbank] (combinational from state only, not from in_valid).
//  - Write: on in_valid&&in_ready, mem[wbank][bitrev(wcnt)] <= {in_r,in_i};
//    wcnt++. When wcnt==N-1 is accepted: wcnt wraps to 0, full[wbank]<=1,
//    wbank toggles.
//  - Output register loads when full[rbank] && (!out_valid || out_ready):
//    out_r/out_i <= mem[rbank][rcnt], out_first <= (rcnt==0),
//    out_last <= (rcnt==N-1), out_valid <= 1, rcnt++.
//    Loading rcnt==N-1: rcnt wraps, full[rbank]<=0, rbank toggles.
//  - If no load and out_ready: out_valid<=0. While out_valid&&!out_ready all
//    output regs hold stable.
//  - Latency: last sample of a frame accepted in cycle T -> out_valid=1 with
//    out_first in cycle T+2 (given out_ready high at T+1 or out_valid low).
//  - Same-cycle set of full[wbank] and clear of full[rbank]: banks always differ
//    when both occur; both updates take effect.
//  - Both banks full: in_ready=0 until the read side releases a bank; in_ready
//    rises the cycle after the final sample of the draining frame is loaded.
//  - Continuous in_valid=1, out_ready=1: in_ready never drops; output is gapless
//    after the first frame's latency.
//  - No arithmetic on data; widths pass through unchanged.
// STRUCTURE
//  - Package fft_pkg: N, LOG2N, DW constants; function bitrev(LOG2N-bit idx);
//    typedef for a complex sample {DW real, DW imag}.
//  - Sub-module fft_reorder_bank: N x 2*DW storage, one synchronous write port,
//    one combinational read port; instantiated twice (bank 0/1).
//  - Top holds counters, bank pointers, full flags and output register.
// TESTING
//  1. Reset: assert rst mid-frame (wcnt=17) -> out_valid=0, in_ready=1, outputs
//     0; following full frame reorders correctly from index 0.
//  2. Single frame: arrival j carries in_r=bitrev(j), in_i=-bitrev(j) -> out_r=
//     0,1,..,31 in order; out_first with 0, out_last with 31; first out_valid
//     exactly 2 cycles after 32nd accept.
//  3. Three back-to-back frames, out_ready=1 -> in_ready stays 1; 96 contiguous
//     natural-order outputs with no bubble after the first.
//  4. out_ready=0 throughout -> in_ready falls right after the 64th accept;
//     out_r/out_i/out_valid hold stable; raising out_ready drains 64 in order.
//  5. Random in_valid/out_ready (50%) over 200 frames -> scoreboard match,
//     frame markers correct, no loss or duplication.
//  6. Extremes: in_r=15'h4000, in_i=15'h3FFF -> emitted bit-exact.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type and index helper for the FFT output reorder path.
package fft_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 15;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } sample_t;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] idx
  );
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = idx[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame of sample storage: synchronous write, combinational read.
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [2*DW-1:0]  wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [2*DW-1:0]  rdata
);

  logic [2*DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed arrival order in, natural order out.
module fft_bitrev_reorder
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_r,
  input  logic [DW-1:0] in_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic          out_first,
  output logic          out_last
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic             wbank;
  logic             rbank;
  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic [1:0]       full;
  logic [1:0]       full_n;

  logic             wr_en;
  logic             load;
  logic             wr_wrap;
  logic             rd_wrap;
  logic [LOG2N-1:0] waddr;
  sample_t          wdata;
  sample_t          rd0;
  sample_t          rd1;
  sample_t          rdata;

  assign in_ready = !full[wbank];
  assign wr_en    = in_valid && in_ready;
  assign load     = full[rbank] && (!out_valid || out_ready);
  assign wr_wrap  = wr_en && (wcnt == LAST);
  assign rd_wrap  = load && (rcnt == LAST);

  assign waddr = bitrev(wcnt);
  assign wdata = '{re: in_r, im: in_i};
  assign rdata = rbank ? rd1 : rd0;

  fft_reorder_bank u_bank0 (
    .clk   (clk),
    .we    (wr_en && !wbank),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt),
    .rdata (rd0)
  );

  fft_reorder_bank u_bank1 (
    .clk   (clk),
    .we    (wr_en && wbank),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt),
    .rdata (rd1)
  );

  // A bank being filled is never full and a bank being drained is, so
  // the set and clear below can never target the same bank.
  always_comb begin
    full_n = full;
    if (wr_wrap) begin
      full_n[wbank] = 1'b1;
    end
    if (rd_wrap) begin
      full_n[rbank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank <= 1'b0;
      wcnt  <= '0;
      full  <= '0;
    end else begin
      full <= full_n;
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wr_wrap) begin
          wbank <= ~wbank;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbank     <= 1'b0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_r     <= rdata.re;
      out_i     <= rdata.im;
      out_first <= (rcnt == '0);
      out_last  <= (rcnt == LAST);
      rcnt      <= rcnt + 1'b1;
      if (rd_wrap) begin
        rbank <= ~rbank;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed and scoreboard bench for fft_bitrev_reorder.
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_r;
  logic [DW-1:0] out_i;
  logic          out_first;
  logic          out_last;

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_first (out_first),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_i;
    logic [DW-1:0] exp_r;
    logic [DW-1:0] exp_i;
    logic          exp_first;
    logic          exp_last;
  } vec_t;

  vec_t    tv [N];
  sample_t sb_q [$];
  sample_t wbuf [N];

  int         nchk = 0;
  int         nerr = 0;
  int         n_out;
  int         n_acc;
  logic [4:0] src_j;
  logic [9:0] src_frame;
  logic [4:0] out_idx;
  logic       xmode;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_r = '0;
    in_i = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    src_j = '0;
    src_frame = '0;
    out_idx = '0;
    n_out = 0;
    n_acc = 0;
    xmode = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_r"}, out_r, 0);
    chk({tag, "_out_i"}, out_i, 0);
    chk({tag, "_first"}, out_first, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  // One clock: drive, score the handshakes about to fire, advance.
  task automatic cycle(input logic iv, input logic ordy);
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          acc;
    logic          otx;
    sample_t       e;
    r = DW'({src_frame, bitrev(src_j)});
    i = ~r;
    if (xmode && src_j == 5'd0) begin
      r = 15'h4000;
      i = 15'h3FFF;
    end
    if (xmode && src_j == 5'd1) begin
      r = 15'h7FFF;
      i = 15'h0000;
    end
    in_valid = iv;
    in_r = r;
    in_i = i;
    out_ready = ordy;
    acc = iv && in_ready;
    otx = out_valid && ordy;
    if (otx) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_r", out_r, e.re);
        chk("sb_i", out_i, e.im);
        chk("sb_first", out_first, out_idx == 5'd0);
        chk("sb_last", out_last, out_idx == 5'd31);
        if (xmode && out_idx == 5'd0) begin
          chk("ext_r", out_r, 15'h4000);
          chk("ext_i", out_i, 15'h3FFF);
        end
      end
      out_idx++;
      n_out++;
    end
    if (acc) begin
      wbuf[bitrev(src_j)] = '{re: r, im: i};
      if (src_j == 5'd31) begin
        for (int k = 0; k < N; k++) sb_q.push_back(wbuf[k]);
        src_frame++;
      end
      src_j++;
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm, input int exp_n);
    for (int c = 0; c < 400 && n_out < exp_n; c++) cycle(1'b0, 1'b1);
    chk(nm, n_out, exp_n);
  endtask

  int   drops;
  int   bubbles;
  int   changes;
  int   vcnt;
  logic started;
  logic snapped;
  logic [2*DW:0] snap;

  initial begin
    for (int j = 0; j < N; j++) begin
      tv[j].in_r = DW'(bitrev(5'(j)));
      tv[j].in_i = DW'(0) - DW'(bitrev(5'(j)));
      tv[j].exp_r = DW'(j);
      tv[j].exp_i = DW'(0) - DW'(j);
      tv[j].exp_first = (j == 0);
      tv[j].exp_last = (j == N - 1);
    end

    do_reset();
    chk_idle("rst0");

    // Reset with one buffered frame and 17 samples of the next.
    for (int c = 0; c < 32 + 17; c++) cycle(1'b1, 1'b0);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    src_j = '0;
    src_frame = 10'd5;
    out_idx = '0;
    n_out = 0;
    n_acc = 0;
    chk_idle("rst_mid");
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1);
      if (out_valid) vcnt++;
    end
    chk("rst_no_output", vcnt, 0);
    for (int c = 0; c < 32; c++) cycle(1'b1, 1'b1);
    drain("rst_refill_count", 32);

    // Single frame from the vector table, including latency.
    do_reset();
    out_ready = 1'b1;
    for (int j = 0; j < N; j++) begin
      in_valid = 1'b1;
      in_r = tv[j].in_r;
      in_i = tv[j].in_i;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("lat_t1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_t2_valid", out_valid, 1);
    for (int j = 0; j < N; j++) begin
      chk("tv_valid", out_valid, 1);
      chk("tv_r", out_r, tv[j].exp_r);
      chk("tv_i", out_i, tv[j].exp_i);
      chk("tv_first", out_first, tv[j].exp_first);
      chk("tv_last", out_last, tv[j].exp_last);
      @(posedge clk);
      #1;
    end
    chk("tv_end_valid", out_valid, 0);

    // Three back-to-back frames, no stall on either side.
    do_reset();
    drops = 0;
    bubbles = 0;
    started = 1'b0;
    for (int c = 0; c < 3 * N + 40; c++) begin
      if (n_acc < 3 * N && !in_ready) drops++;
      cycle(n_acc < 3 * N, 1'b1);
      if (out_valid) started = 1'b1;
      else if (started && n_out < 3 * N) bubbles++;
    end
    chk("b2b_drops", drops, 0);
    chk("b2b_bubbles", bubbles, 0);
    chk("b2b_count", n_out, 3 * N);

    // Downstream stalled: both banks fill, output holds.
    do_reset();
    snapped = 1'b0;
    changes = 0;
    for (int c = 0; c < 70; c++) begin
      cycle(1'b1, 1'b0);
      if (snapped) begin
        if ({out_valid, out_r, out_i} !== snap) changes++;
      end else if (out_valid) begin
        snapped = 1'b1;
        snap = {out_valid, out_r, out_i};
      end
    end
    chk("stall_accepts", n_acc, 64);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_valid", out_valid, 1);
    chk("stall_first", out_first, 1);
    chk("stall_changes", changes, 0);
    drain("stall_drain", 64);
    chk("stall_in_ready_back", in_ready, 1);

    // Random handshakes over 200 frames.
    do_reset();
    for (int c = 0; c < 40000 && n_acc < 200 * N; c++) begin
      cycle((n_acc < 200 * N) && ($urandom_range(0, 1) == 1),
            $urandom_range(0, 1) == 1);
    end
    chk("rand_accepts", n_acc, 200 * N);
    drain("rand_count", 200 * N);
    chk("rand_sb_empty", sb_q.size(), 0);

    // Extreme component values pass bit-exact.
    do_reset();
    xmode = 1'b1;
    for (int c = 0; c < 2 * N; c++) cycle(1'b1, 1'b1);
    drain("ext_count", 2 * N);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
